bin_reorder: RTL and testbench
==============================

BIN_REORDER -- requirements
Module: bin_reorder

Interface
REQ-001 SHALL have parameter L, default 9: log2 of frame length N = 2^L.
REQ-002 SHALL have parameter W, default 16: width of each real and imaginary sample component.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re (input, W), in_im (input, W): bins arriving in bit-reversed order.
REQ-006 SHALL have port in_last, input, 1 bit: marks the final bin of an input frame.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_re (output, W), out_im (output, W), out_idx (output, L), out_last (output, 1): bins leaving in natural order.
REQ-008 SHALL have port frame_err, output, 1 bit: sticky flag for a misaligned in_last.

Function
REQ-009 SHALL store bins in two banks (ping-pong), each N x 2W.
REQ-010 SHALL accept an input beat when in_valid && in_ready, writing it to address bitrev(wcnt) of the write bank, where bitrev mirrors bit i to bit L-1-i.
REQ-011 SHALL increment wcnt after each accepted beat; at wcnt = N-1 it SHALL wrap to 0, mark the write bank full and toggle the write bank.
REQ-012 SHALL drive in_ready = 1 only while the current write bank is not full.
REQ-013 SHALL use a read FSM with states IDLE, STREAM and DRAIN.
REQ-014 SHALL move the read FSM from IDLE to STREAM when the read bank is full.
REQ-015 SHALL issue sequential reads rcnt = 0..N-1 in STREAM; rcnt advances only when the output register is empty or being consumed.
REQ-016 SHALL move to DRAIN after issuing read N-1, then return to IDLE when the last beat is accepted; at that point it SHALL clear the bank's full flag and toggle the read bank.
REQ-017 SHALL register all outputs, with 2 cycles of latency from the first read issue to out_valid; no bubbles while out_ready is held high.
REQ-018 SHALL hold out_re, out_im, out_idx and out_last stable while out_valid && !out_ready.
REQ-019 SHALL set out_idx = natural bin index and out_last = 1 when out_idx = N-1.
REQ-020 SHALL, when the read side frees a bank in the same cycle the write side fills the other, accept both events with no lost or duplicated beat.
REQ-021 SHALL sustain continuous throughput of one beat per cycle in steady state.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear wcnt, rcnt, bank selects, full flags, out_valid, out_last, out_idx, out_re, out_im and frame_err to 0, and put the FSM in IDLE.
REQ-023 SHALL, on reset asserted mid-frame, discard all partial and full frames; the first beat after release SHALL be written to bitrev(0) of bank 0.
REQ-024 SHALL keep RAM contents unreset.

Configuration
REQ-025 SHALL, with macro BIN_REORDER_FRAME_CHECK_EN defined, on an accepted in_last with wcnt != N-1, set frame_err (sticky until reset), reset wcnt to 0 and leave the bank not full (partial frame dropped).
REQ-026 SHALL, without BIN_REORDER_FRAME_CHECK_EN, ignore in_last, tie frame_err to 0 and frame solely by wcnt wrap.

Structure
REQ-027 SHALL take the default L and W values and the read FSM state enum from the shared FFT package.
REQ-028 SHALL implement the bank storage as one sub-module, bin_bank_ram: a simple dual-port RAM with one write port and one registered read port, instantiated once with a bank-select address bit.
REQ-029 SHALL implement bitrev as a pure function in the shared package.

Verification (L=3, W=16)
REQ-030 SHALL pass: feed re = bitrev(k) for k = 0..7 with out_ready = 1 -> out_re = 0,1,...,7 and out_idx = 0..7, out_last only on 7.
REQ-031 SHALL pass: three back-to-back frames with in_valid held high and out_ready = 1 -> in_ready never drops after the first frame and 24 outputs arrive in order.
REQ-032 SHALL pass: out_ready = 0 while two frames are sent -> in_ready = 0 after 16 beats; releasing out_ready yields frame 1 then frame 2 intact.
REQ-033 SHALL pass: out_ready toggled every cycle -> each beat is held stable until accepted, with no duplicate or skipped idx.
REQ-034 SHALL pass: reset_n pulsed low after 5 beats of a frame -> out_valid = 0 immediately, and the next full frame reorders correctly.
REQ-035 SHALL pass: with BIN_REORDER_FRAME_CHECK_EN defined, in_last asserted on beat 4 -> frame_err = 1, no output, and the following aligned frame is output correctly.

Source files
------------

// File: rtl/bin_reorder_pkg.sv
// +--------------------------------------------------------------------+
// | Module      : bin_reorder_pkg                                      |
// | Description : Shared FFT definitions: default frame geometry, the  |
// |               reorder read-FSM state encoding and bit reversal.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

package bin_reorder_pkg;

    // Default log2 frame length and sample component width
    localparam int c_fft_l = 9;
    localparam int c_fft_w = 16;

    // Read-side sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } rd_state_t;

    // Mirror the low 'bits' bits of v (bit i goes to bit bits-1-i)
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) begin
                r[5'(bits - 1 - i)] = v[5'(i)];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin_bank_ram.sv
// +--------------------------------------------------------------------+
// | Module      : bin_bank_ram                                         |
// | Description : Simple dual-port RAM, one write port and one         |
// |               registered read port; contents are never reset.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module bin_bank_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read; data holds while re is low so a stalled pipeline keeps its word
    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/bin_reorder.sv
// +--------------------------------------------------------------------+
// | Module      : bin_reorder                                          |
// | Description : Ping-pong reorder buffer turning bit-reversed FFT    |
// |               bins into natural order. Optional macro              |
// |               BIN_REORDER_FRAME_CHECK_EN enables in_last checking. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module bin_reorder
    import bin_reorder_pkg::*;
#(
    parameter int L = c_fft_l,
    parameter int W = c_fft_w
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [L-1:0] out_idx,
    output logic         out_last,
    output logic         frame_err
);

    localparam logic [L-1:0] c_last = '1;

    // Write side
    logic [L-1:0]   r_wcnt;
    logic           r_wbank;
    logic [1:0]     r_full;
    logic           w_in_fire;
    logic           w_wr_wrap;
    logic           w_wr_abort;
    logic [L-1:0]   w_wr_addr;

    // Read side
    rd_state_t      r_state;
    rd_state_t      w_state_nxt;
    logic [L-1:0]   r_rcnt;
    logic           r_rbank;
    logic           r_s1_valid;
    logic [L-1:0]   r_s1_idx;
    logic           r_out_valid;
    logic [W-1:0]   r_out_re;
    logic [W-1:0]   r_out_im;
    logic [L-1:0]   r_out_idx;
    logic           r_out_last;
    logic           w_advance;
    logic           w_issue;
    logic           w_out_fire;
    logic           w_rd_done;
    logic [2*W-1:0] w_rd_data;

    assign in_ready   = !r_full[r_wbank];
    assign w_in_fire  = in_valid && in_ready;
    assign w_wr_wrap  = w_in_fire && (r_wcnt == c_last);
    assign w_wr_addr  = L'(bitrev(32'(r_wcnt), L));

`ifdef BIN_REORDER_FRAME_CHECK_EN
    logic r_frame_err;

    // An early in_last drops the partial frame instead of wrapping the bank
    assign w_wr_abort = w_in_fire && in_last && (r_wcnt != c_last);
    assign frame_err  = r_frame_err;

    // Sticky misalignment flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
        end else if (w_wr_abort) begin
            r_frame_err <= 1'b1;
        end
    end
`else
    logic w_unused_in_last;

    // Framing is purely by count wrap; in_last carries no meaning here
    assign w_unused_in_last = in_last;
    assign w_wr_abort       = 1'b0;
    assign frame_err        = 1'b0;
`endif

    // Write counter and write bank select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (w_in_fire) begin
            if (w_wr_abort) begin
                r_wcnt <= '0;
            end else if (w_wr_wrap) begin
                r_wcnt  <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_wcnt <= r_wcnt + L'(1);
            end
        end
    end

    // Full flags: the two sides always touch different banks, so fill and free can coincide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 2'b00;
        end else begin
            if (w_rd_done) begin
                r_full[r_rbank] <= 1'b0;
            end
            if (w_wr_wrap) begin
                r_full[r_wbank] <= 1'b1;
            end
        end
    end

    assign w_advance  = !r_out_valid || out_ready;
    assign w_issue    = (r_state == ST_STREAM) && w_advance;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_rd_done  = w_out_fire && r_out_last && (r_state == ST_DRAIN);

    // Read FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (r_full[r_rbank])                 w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_issue && (r_rcnt == c_last))   w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_rd_done)                       w_state_nxt = ST_IDLE;
            default:                                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Read pipeline: issue -> RAM register (stage 1) -> output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rcnt      <= '0;
            r_rbank     <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rcnt <= r_rcnt + L'(1);
            end
            if (w_rd_done) begin
                r_rbank <= ~r_rbank;
            end
            if (w_advance) begin
                r_s1_valid  <= w_issue;
                r_out_valid <= r_s1_valid;
                if (w_issue) begin
                    r_s1_idx <= r_rcnt;
                end
                if (r_s1_valid) begin
                    r_out_re   <= w_rd_data[2*W-1:W];
                    r_out_im   <= w_rd_data[W-1:0];
                    r_out_idx  <= r_s1_idx;
                    r_out_last <= (r_s1_idx == c_last);
                end
            end
        end
    end

    bin_bank_ram #(
        .AW (L + 1),
        .DW (2 * W)
    ) u_ram (
        .clk   (clk),
        .we    (w_in_fire),
        .waddr ({r_wbank, w_wr_addr}),
        .wdata ({in_re, in_im}),
        .re    (w_issue),
        .raddr ({r_rbank, r_rcnt}),
        .rdata (w_rd_data)
    );

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_bin_reorder.sv
// +--------------------------------------------------------------------+
// | Module      : tb_bin_reorder                                       |
// | Description : Self-checking bench for bin_reorder (L=3, W=16) with |
// |               a frame-level reference model and scoreboard.        |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_bin_reorder;

    localparam int L = 3;
    localparam int W = 16;
    localparam int N = 8;
`ifdef BIN_REORDER_FRAME_CHECK_EN
    localparam bit c_frame_chk = 1'b1;
`else
    localparam bit c_frame_chk = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic [L-1:0] out_idx;
    logic         out_last;
    logic         frame_err;

    bin_reorder #(.L(L), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rdy_mode;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        int          idx;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] in_re;
        logic [15:0] in_im;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
        int          exp_idx;
        logic        exp_last;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [15:0] m_re [N];
    logic [15:0] m_im [N];
    int          m_cnt = 0;
    logic        held = 1'b0;
    logic [63:0] held_val;

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < L; i++) begin
            if ((k & (1 << i)) != 0) r = r | (1 << (L - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a completed frame emits natural bin j = arrival position brev(j)
    task automatic model_accept();
        m_re[m_cnt] = in_re;
        m_im[m_cnt] = in_im;
        if (c_frame_chk && in_last && m_cnt != N - 1) begin
            m_cnt = 0;
        end else if (m_cnt == N - 1) begin
            for (int j = 0; j < N; j++) begin
                beat_t b;
                b.re   = m_re[brev(j)];
                b.im   = m_im[brev(j)];
                b.idx  = j;
                b.last = (j == N - 1);
                exp_q.push_back(b);
            end
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer readiness pattern
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", {28'd0, out_re, out_im, out_idx, out_last}, held_val);
            end
            if (in_valid && in_ready) model_accept();
            if (out_valid && out_ready) begin
                beat_t o;
                o.re = out_re; o.im = out_im; o.idx = int'(out_idx); o.last = out_last;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=idx%0d expected=none", out_idx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_re", 64'(out_re), 64'(e.re));
                    chk("out_im", 64'(out_im), 64'(e.im));
                    chk("out_idx", 64'(out_idx), 64'(e.idx));
                    chk("out_last", 64'(out_last), 64'(e.last));
                end
            end
            held     = out_valid && !out_ready;
            held_val = {28'd0, out_re, out_im, out_idx, out_last};
        end
    end

    task automatic send_beat(input logic [15:0] re, input logic [15:0] im,
                             input logic last, output int waits);
        logic ok;
        in_valid = 1'b1; in_re = re; in_im = im; in_last = last;
        waits = 0;
        while (1) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits >= 300) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout actual=%0d expected<300", waits);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_random_frames(input int frames, input bit gaps, output int sum_waits);
        int w;
        sum_waits = 0;
        for (int k = 0; k < frames * N; k++) begin
            logic lst;
            lst = c_frame_chk ? ((k % N) == N - 1) : 1'($urandom_range(0, 1));
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
            send_beat(16'($urandom), 16'($urandom), lst, w);
            sum_waits += w;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 600) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t < 600), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_out_word", {29'd0, out_re, out_im, out_idx, out_last}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t tbl [N];
        int   w;
        int   t;
        int   c0;

        reset_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
        out_ready = 1'b1; rdy_mode = 1;
        #2;
        do_reset();

        // Table: re = bitrev(k) in arrival order must come out as 0..7
        for (int k = 0; k < N; k++) begin
            tbl[k].in_re    = 16'(brev(k));
            tbl[k].in_im    = 16'(16'h100 + k);
            tbl[k].exp_re   = 16'(k);
            tbl[k].exp_im   = 16'(16'h100 + brev(k));
            tbl[k].exp_idx  = k;
            tbl[k].exp_last = (k == N - 1);
        end
        obs_q.delete();
        for (int k = 0; k < N; k++) send_beat(tbl[k].in_re, tbl[k].in_im, k == N - 1, w);
        drain();
        chk("tbl_count", 64'(obs_q.size()), 64'(N));
        for (int k = 0; k < N && k < obs_q.size(); k++) begin
            chk("tbl_re", 64'(obs_q[k].re), 64'(tbl[k].exp_re));
            chk("tbl_im", 64'(obs_q[k].im), 64'(tbl[k].exp_im));
            chk("tbl_idx", 64'(obs_q[k].idx), 64'(tbl[k].exp_idx));
            chk("tbl_last", 64'(obs_q[k].last), 64'(tbl[k].exp_last));
        end

        // Three back-to-back frames at full rate
        obs_q.delete();
        c0 = cyc;
        t = 0;
        for (int k = 0; k < 3 * N; k++) begin
            send_beat(16'($urandom), 16'($urandom), (k % N) == N - 1, w);
            if (k >= N && k < 2 * N) t += w;
        end
        chk("b2b_frame2_stall", 64'(t), 64'd0);
        chk("b2b_rate", 64'((cyc - c0) <= 3 * N + 12), 64'd1);
        drain();
        chk("b2b_count", 64'(obs_q.size()), 64'(3 * N));

        // Consumer stalled: both banks fill, then the writer must block
        rdy_mode = 0;
        @(posedge clk);
        #1;
        obs_q.delete();
        for (int k = 0; k < 2 * N; k++) send_beat(16'($urandom), 16'($urandom), (k % N) == N - 1, w);
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        rdy_mode = 1;
        drain();
        chk("stall_count", 64'(obs_q.size()), 64'(2 * N));

        // Consumer toggling every cycle
        rdy_mode = 2;
        obs_q.delete();
        send_random_frames(2, 1'b0, w);
        drain();
        chk("toggle_count", 64'(obs_q.size()), 64'(2 * N));

        // Reset in the middle of a frame while output is pending
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) send_beat(16'($urandom), 16'($urandom), k == N - 1, w);
        for (int k = 0; k < 5; k++) send_beat(16'($urandom), 16'($urandom), 1'b0, w);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        do_reset();
        rdy_mode = 1;
        obs_q.delete();
        for (int k = 0; k < N; k++) send_beat(16'(16'h50 + k), 16'(k), k == N - 1, w);
        drain();
        chk("post_rst_count", 64'(obs_q.size()), 64'(N));
        if (obs_q.size() > 1) chk("post_rst_bin1", 64'(obs_q[1].re), 64'(16'h50 + brev(1)));

        // Randomised traffic on both sides
        rdy_mode = 3;
        obs_q.delete();
        send_random_frames(6, 1'b1, w);
        rdy_mode = 1;
        drain();
        chk("rand_count", 64'(obs_q.size()), 64'(6 * N));
        chk("rand_frame_err", 64'(frame_err), 64'd0);

`ifdef BIN_REORDER_FRAME_CHECK_EN
        // Early in_last drops the partial frame and latches frame_err
        obs_q.delete();
        for (int k = 0; k < 4; k++) send_beat(16'($urandom), 16'($urandom), k == 3, w);
        repeat (20) @(posedge clk);
        #1;
        chk("ferr_set", 64'(frame_err), 64'd1);
        chk("ferr_no_out", 64'(obs_q.size()), 64'd0);
        for (int k = 0; k < N; k++) send_beat(16'($urandom), 16'($urandom), k == N - 1, w);
        drain();
        chk("ferr_next_count", 64'(obs_q.size()), 64'(N));
        chk("ferr_sticky", 64'(frame_err), 64'd1);
`endif

        chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
